ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- Receives PS/2 keyboard frames on kbclck/kbdata and checks each frame's start, parity and stop bits.
- Emits raw bytes, then folds the 0xE0 (extended) and 0xF0 (break) prefixes into one key event per keystroke.
- Sits directly between the PS/2 pins and the command/display logic inside Proyecto2_Top.
- `en` gates the start of a new frame only; a frame already in progress always completes.

Parameters:
- FILTER_LEN, 8: consecutive identical clk samples needed before the filtered kbclck/kbdata change value.
- TIMEOUT_CYC, 100000: clk cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- kbclck  in  1  PS/2 clock from keyboard, asynchronous.
- kbdata  in  1  PS/2 data from keyboard, asynchronous.
- en  in  1  receive enable; sampled only in IDLE.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- key_code  out  8  scan code of the last key event.
- key_valid  out  1  one-cycle pulse per key event.
- key_break  out  1  1 = release event (0xF0 seen); valid with key_valid.
- key_ext  out  1  1 = extended key (0xE0 seen); valid with key_valid.
- frame_err  out  1  one-cycle pulse on bad start, parity or stop bit, or on timeout.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - FSM goes to IDLE; break_pend and ext_pend are cleared.
  - Synchronizer and filter registers are set to 1 (idle bus).
- Input conditioning:
  - kbclck and kbdata each pass through a 2-FF synchronizer, then a FILTER_LEN-sample stability filter.
  - A falling edge is filtered kbclck going 1 to 0.
  - Filtered kbdata is sampled in the same clk cycle the falling edge is detected.
- FSM states:
  - IDLE:
    - A falling edge with en=1 and data=0 goes to SHIFT with bit count 0; busy=1.
    - A falling edge with en=0 is ignored.
    - A falling edge with data=1 is ignored; no error.
  - SHIFT:
    - Eight falling edges each shift data in LSB-first, then one edge captures the parity bit, then one edge captures the stop bit.
    - After the stop edge, go to CHECK.
  - CHECK (exactly 1 cycle):
    - Good frame: odd parity over 8 data bits + parity bit, and stop=1. Then rx_byte updates and rx_valid=1.
    - Bad frame: frame_err=1, rx_byte is unchanged, and the prefix flags are unchanged.
    - Always return to IDLE; busy=0.
  - Timeout: a cycle counter resets on every falling edge while busy. Reaching TIMEOUT_CYC forces IDLE, pulses frame_err and leaves the prefix flags unchanged.
- Latency: rx_valid is asserted 1 clk after the cycle in which the stop-bit falling edge is detected.
- Key decode, applied in the CHECK cycle of a good frame:
  - Byte 0xF0: break_pend=1; no key_valid.
  - Byte 0xE0: ext_pend=1; no key_valid.
  - Any other byte:
    - Same cycle as rx_valid: key_valid=1, key_code=byte, key_break=break_pend, key_ext=ext_pend.
    - Both pending flags then clear.
- key_code, key_break and key_ext hold their values until the next key event.
- Repeated prefixes are idempotent: F0 F0 behaves as F0.
- en going 0 mid-frame has no effect on the current frame.
- Reset mid-frame: the frame is discarded and no pulses are produced.
- Received codes 0x00 and 0xFF are reported as normal keys.

Test Plan:
- Frame 0x2A (parity 0, stop 1), en=1 -> rx_byte=0x2A, rx_valid pulse, key_valid with key_code=0x2A, key_break=0, key_ext=0.
- Sequence 0x2A, 0xF0 (parity 1), 0x2A, with en dropped to 0 during each stop bit -> two key events: 0x2A with break=0, then 0x2A with break=1; rx_valid pulses for 0xF0 but no key_valid.
- Sequence 0xE0, 0xF0, 0x75 (parity 0) -> a single key event: code 0x75, key_ext=1, key_break=1; the next 0x1C (parity 0) gives ext=0, break=0.
- Frame 0x1C with parity bit 1 -> frame_err pulse, no rx_valid, rx_byte unchanged; a following good 0xF0 then 0x1C gives break=1.
- 4 falling edges followed by silence > TIMEOUT_CYC -> frame_err pulse, busy=0; the next full 0x2A frame is received correctly.
- en=0 while the keyboard sends a start bit -> frame ignored, no pulses. Separately, reset asserted after bit 5 of a frame -> all outputs 0, and a subsequent frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and debounces kbclck/kbdata, validates
// 11-bit frames and folds the E0/F0 prefixes into one key event per keystroke.
module ps2_scancode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbclck,
  input  logic       kbdata,
  input  logic       en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t          state;
  logic [1:0]      clk_sync, dat_sync;
  logic [1:0]      raw, filt;
  logic [FW-1:0]   fcnt [2];
  logic            clk_filt_d;
  logic            fall, dat;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic            break_pend, ext_pend;
  logic [TW-1:0]   tcnt;

  // Index 0 is the PS/2 clock, index 1 is the PS/2 data line.
  assign raw  = {dat_sync[1], clk_sync[1]};
  assign dat  = filt[1];
  assign fall = clk_filt_d & ~filt[0];

  // NOTE: synchronizer and filter reset to 1 so an idle bus does not look like
  // a falling edge right after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt       <= 2'b11;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], kbclck};
      dat_sync   <= {dat_sync[0], kbdata};
      clk_filt_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: every state register here uses <= so all updates in a cycle see the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_break  <= 1'b0;
      key_ext    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall && en && !dat) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (fall) begin
            tcnt    <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              shift <= {dat, shift[7:1]};
            end else if (bit_cnt == 4'd8) begin
              par_bit <= dat;
            end else begin
              // Stop edge: judge the frame now so the pulses line up with CHECK.
              state <= CHECK;
              if ((^{shift, par_bit}) && dat) begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
                if (shift == 8'hF0) begin
                  break_pend <= 1'b1;
                end else if (shift == 8'hE0) begin
                  ext_pend <= 1'b1;
                end else begin
                  key_valid  <= 1'b1;
                  key_code   <= shift;
                  key_break  <= break_pend;
                  key_ext    <= ext_pend;
                  break_pend <= 1'b0;
                  ext_pend   <= 1'b0;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames are bit-banged on kbclck/kbdata and
// a monitor scores rx/key/error pulses against hand-written expectations.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } key_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kbclck = 1'b1;
  logic       kbdata = 1'b1;
  logic       en = 1'b0;
  logic [7:0] rx_byte, key_code;
  logic       rx_valid, key_valid, key_break, key_ext, frame_err, busy;

  logic [7:0] exp_rx [$];
  key_t       exp_key [$];
  int         exp_err = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .kbclck(kbclck), .kbdata(kbdata), .en(en),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .key_code(key_code),
    .key_valid(key_valid), .key_break(key_break), .key_ext(key_ext),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Drives the first nedges bits of a frame; optionally drops en during the stop bit.
  task automatic send_edges(input logic [10:0] bits, input int nedges, input bit drop_en);
    for (int i = 0; i < nedges; i++) begin
      if (drop_en && i == 10) en = 1'b0;
      kbdata = bits[i];
      wait_clk(HALF);
      kbclck = 1'b0;
      wait_clk(HALF);
      kbclck = 1'b1;
    end
    kbdata = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send(input logic [7:0] d, input logic p, input bit drop_en);
    send_edges(frame(d, p), 11, drop_en);
    en = 1'b1;
  endtask

  task automatic expect_key(input logic [7:0] c, input logic b, input logic x);
    key_t k;
    k.code = c;
    k.brk  = b;
    k.ext  = x;
    exp_key.push_back(k);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_byte"},   32'(rx_byte),   32'h0);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
    check({tag, "_key_code"},  32'(key_code),  32'h0);
    check({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_key_break"}, 32'(key_break), 32'h0);
    check({tag, "_key_ext"},   32'(key_ext),   32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  // Monitor: scores each output pulse against the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h, expected no rx_valid", rx_byte);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
        end
      end
      if (key_valid) begin
        if (exp_key.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL key_unexpected: got %0h, expected no key_valid", key_code);
        end else begin
          key_t k;
          k = exp_key.pop_front();
          check("key_code",  32'(key_code),  32'(k.code));
          check("key_break", 32'(key_break), 32'(k.brk));
          check("key_ext",   32'(key_ext),   32'(k.ext));
        end
      end
      if (frame_err) begin
        n_checks++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: got frame_err=1, expected 0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clk(5);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    en    = 1'b1;
    wait_clk(20);

    // Plain make code.
    exp_rx.push_back(8'h2A); expect_key(8'h2A, 1'b0, 1'b0);
    send(8'h2A, 1'b0, 1'b0);
    check("t1_rx_byte", 32'(rx_byte), 32'h2A);

    // Make / break with en dropped during each stop bit.
    exp_rx.push_back(8'h2A); expect_key(8'h2A, 1'b0, 1'b0);
    send(8'h2A, 1'b0, 1'b1);
    exp_rx.push_back(8'hF0);
    send(8'hF0, 1'b1, 1'b1);
    check("t2_hold_code",  32'(key_code),  32'h2A);
    check("t2_hold_break", 32'(key_break), 32'h0);
    exp_rx.push_back(8'h2A); expect_key(8'h2A, 1'b1, 1'b0);
    send(8'h2A, 1'b0, 1'b1);

    // Extended break, then flags cleared.
    exp_rx.push_back(8'hE0);
    send(8'hE0, 1'b0, 1'b0);
    exp_rx.push_back(8'hF0);
    send(8'hF0, 1'b1, 1'b0);
    exp_rx.push_back(8'h75); expect_key(8'h75, 1'b1, 1'b1);
    send(8'h75, 1'b0, 1'b0);
    exp_rx.push_back(8'h1C); expect_key(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Codes 00 and FF are ordinary keys.
    exp_rx.push_back(8'h00); expect_key(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    exp_rx.push_back(8'hFF); expect_key(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);

    // Parity error, then repeated F0 still yields a single break.
    exp_err++;
    send(8'h1C, 1'b1, 1'b0);
    check("t4_rx_byte_kept", 32'(rx_byte), 32'hFF);
    exp_rx.push_back(8'hF0);
    send(8'hF0, 1'b1, 1'b0);
    exp_rx.push_back(8'hF0);
    send(8'hF0, 1'b1, 1'b0);
    exp_rx.push_back(8'h1C); expect_key(8'h1C, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b0);

    // Truncated frame times out.
    exp_err++;
    send_edges(frame(8'h2A, 1'b0), 4, 1'b0);
    @(negedge clk);
    check("t5_busy_mid", 32'(busy), 32'h1);
    wait_clk(TIMEOUT_CYC + 200);
    @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'h0);
    exp_rx.push_back(8'h2A); expect_key(8'h2A, 1'b0, 1'b0);
    send(8'h2A, 1'b0, 1'b0);

    // Disabled receiver ignores a whole frame.
    en = 1'b0;
    send_edges(frame(8'h2A, 1'b0), 11, 1'b0);
    @(negedge clk);
    check("t6_busy_disabled", 32'(busy), 32'h0);
    en = 1'b1;

    // Reset in the middle of a frame.
    send_edges(frame(8'h1C, 1'b0), 7, 1'b0);
    reset = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b1;
    wait_clk(20);
    exp_rx.push_back(8'h2A); expect_key(8'h2A, 1'b0, 1'b0);
    send(8'h2A, 1'b0, 1'b0);

    wait_clk(50);
    check("drain_rx",  32'(exp_rx.size()),  32'h0);
    check("drain_key", 32'(exp_key.size()), 32'h0);
    check("drain_err", 32'(exp_err),        32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
